gtfwizard_0_gtf_common_drp_ctrl: RTL and testbench



---
 rtl/gtf_drp_pkg.sv | 22 ++
 rtl/gtf_drp_timeout.sv | 35 +++
 rtl/gtfwizard_0_gtf_common_drp_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gtfwizard_0_gtf_common_drp_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gtf_drp_pkg.sv
// Shared encodings and helpers for the GTF common DRP master.
package gtf_drp_pkg;

   localparam logic [1:0] DRP_OP_RD  = 2'b00;
   localparam logic [1:0] DRP_OP_WR  = 2'b01;
   localparam logic [1:0] DRP_OP_RMW = 2'b10;

   typedef enum logic [1:0] {
      StIdle,
      StRdWait,
      StWrWait,
      StResp
   } drp_state_e;

   // Bits set in mask come from wd, the rest keep the value read back.
   function automatic logic [15:0] drp_merge(input logic [15:0] rd,
                                             input logic [15:0] wd,
                                             input logic [15:0] mask);
      return (rd & ~mask) | (wd & mask);
   endfunction

endpackage

// File: rtl/gtf_drp_timeout.sv
// Saturating 16-bit wait counter; flags expiry once TIMEOUT_CYCLES cycles have elapsed.
module gtf_drp_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [15:0] cnt_q, cnt_d;

   // Clear wins over count; hold at all-ones so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired_o = (cnt_q >= 16'(TIMEOUT_CYCLES));

endmodule

// File: rtl/gtfwizard_0_gtf_common_drp_ctrl.sv
// DRP master for the GTF common block: single read, write and read-modify-write with timeout.
module gtfwizard_0_gtf_common_drp_ctrl
   import gtf_drp_pkg::*;
#(
   parameter int unsigned ADDR_W         = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic              gtf_cm_drpclk,
   input  logic              gtf_cm_drprst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [15:0]       req_wdata,
   input  logic [15:0]       req_wmask,
   output logic              rsp_valid,
   output logic [15:0]       rsp_data,
   output logic              rsp_err,
   output logic              drpen,
   output logic              drpwe,
   output logic [ADDR_W-1:0] drpaddr,
   output logic [15:0]       drpdi,
   input  logic [15:0]       drpdo,
   input  logic              drprdy
);

   drp_state_e        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic [15:0]       wdata_q, wdata_d;
   logic [15:0]       mask_q, mask_d;
   logic              ready_q, ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [15:0]       rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              drpen_q, drpen_d;
   logic              drpwe_q, drpwe_d;
   logic [ADDR_W-1:0] drpaddr_q, drpaddr_d;
   logic [15:0]       drpdi_q, drpdi_d;
   logic              tmo_clr, tmo_en, tmo_expired;
   logic              rdy_ok;
   logic [1:0]        op_norm;
   logic [15:0]       merged;

   // The slave cannot answer in the strobe cycle itself, so ready is only honoured afterwards.
   assign rdy_ok  = drprdy && !drpen_q;
   assign tmo_en  = (state_q == StRdWait) || (state_q == StWrWait);
   assign merged  = drp_merge(drpdo, wdata_q, mask_q);
   // Reserved encoding behaves as a read.
   assign op_norm = (req_op == DRP_OP_WR)  ? DRP_OP_WR  :
                    (req_op == DRP_OP_RMW) ? DRP_OP_RMW : DRP_OP_RD;

   gtf_drp_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk_i     (gtf_cm_drpclk),
      .rst_ni    (gtf_cm_drprst_n),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   // Next-state and registered-output logic for the request/strobe/response sequence.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      wdata_d     = wdata_q;
      mask_d      = mask_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      drpen_d     = 1'b0;
      drpwe_d     = drpwe_q;
      drpaddr_d   = drpaddr_q;
      drpdi_d     = drpdi_q;
      tmo_clr     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid && ready_q) begin
               op_d      = op_norm;
               wdata_d   = req_wdata;
               mask_d    = req_wmask;
               drpaddr_d = req_addr;
               drpen_d   = 1'b1;
               tmo_clr   = 1'b1;
               if (op_norm == DRP_OP_WR) begin
                  drpwe_d = 1'b1;
                  drpdi_d = req_wdata;
                  state_d = StWrWait;
               end else begin
                  drpwe_d = 1'b0;
                  state_d = StRdWait;
               end
            end
         end
         StRdWait: begin
            if (rdy_ok) begin
               if (op_q == DRP_OP_RMW) begin
                  drpen_d = 1'b1;
                  drpwe_d = 1'b1;
                  drpdi_d = merged;
                  tmo_clr = 1'b1;
                  state_d = StWrWait;
               end else begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = drpdo;
                  rsp_err_d   = 1'b0;
                  state_d     = StResp;
               end
            end else if (tmo_expired) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = StResp;
            end
         end
         StWrWait: begin
            if (rdy_ok) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = drpdi_q;
               rsp_err_d   = 1'b0;
               state_d     = StResp;
            end else if (tmo_expired) begin
               rsp_valid_d = 1'b1;
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               state_d     = StResp;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      // Registered so that ready reads low while reset is held.
      ready_d = (state_d == StIdle);
   end

   // State and output registers.
   always_ff @(posedge gtf_cm_drpclk or negedge gtf_cm_drprst_n) begin
      if (!gtf_cm_drprst_n) begin
         state_q     <= StIdle;
         op_q        <= DRP_OP_RD;
         wdata_q     <= '0;
         mask_q      <= '0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         drpen_q     <= 1'b0;
         drpwe_q     <= 1'b0;
         drpaddr_q   <= '0;
         drpdi_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wdata_q     <= wdata_d;
         mask_q      <= mask_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         drpen_q     <= drpen_d;
         drpwe_q     <= drpwe_d;
         drpaddr_q   <= drpaddr_d;
         drpdi_q     <= drpdi_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign drpen     = drpen_q;
   assign drpwe     = drpwe_q;
   assign drpaddr   = drpaddr_q;
   assign drpdi     = drpdi_q;

endmodule

// File: tb/tb_gtfwizard_0_gtf_common_drp_ctrl.sv
// Scoreboard bench for the GTF common DRP master with a latency-programmable DRP slave model.
module tb_gtfwizard_0_gtf_common_drp_ctrl;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] di;
      bit          chk_di;
      int          gap;     // cycles since previous strobe, 0 = not checked
   } strobe_t;

   typedef struct {
      logic [15:0] data;
      logic        err;
      int          gap;     // cycles since last strobe
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [15:0] req_wmask;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        drpen;
   logic        drpwe;
   logic [15:0] drpaddr;
   logic [15:0] drpdi;
   logic [15:0] drpdo;
   logic        drprdy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_strobe = 0;
   int slv_lat = 0;          // 0 = slave never answers
   logic [15:0] slv_rdata = 16'h0000;
   int stray_req = 0;

   strobe_t strobe_q[$];
   rsp_t    rsp_q[$];

   gtfwizard_0_gtf_common_drp_ctrl #(
      .ADDR_W         (16),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .gtf_cm_drpclk   (clk),
      .gtf_cm_drprst_n (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_op          (req_op),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .req_wmask       (req_wmask),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_err         (rsp_err),
      .drpen           (drpen),
      .drpwe           (drpwe),
      .drpaddr         (drpaddr),
      .drpdi           (drpdi),
      .drpdo           (drpdo),
      .drprdy          (drprdy)
   );

   always #5 clk = ~clk;

   initial begin : cycle_count
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // DRP slave: answers slv_lat cycles after a strobe, or pulses drprdy on request.
   initial begin : slave
      int pend;
      int cnt;
      int stray_done;
      pend = 0;
      cnt = 0;
      stray_done = 0;
      drprdy = 1'b0;
      drpdo = 16'h0000;
      forever begin
         @(negedge clk);
         drprdy = 1'b0;
         if (drpen) begin
            pend = slv_lat;
            cnt = 0;
         end else if (pend != 0) begin
            cnt = cnt + 1;
            if (cnt == pend) begin
               drprdy = 1'b1;
               drpdo = slv_rdata;
               pend = 0;
            end
         end
         if (stray_req != stray_done) begin
            stray_done = stray_req;
            drprdy = 1'b1;
            drpdo = 16'hDEAD;
         end
      end
   end

   // Monitor: pops expected strobes and responses whenever the DUT presents them.
   initial begin : monitor
      strobe_t s;
      rsp_t r;
      forever begin
         @(negedge clk);
         if (drpen) begin
            if (strobe_q.size() == 0) begin
               chk("strobe_unexpected", {31'd0, drpwe}, 32'hFFFF_FFFF);
            end else begin
               s = strobe_q.pop_front();
               chk("strobe_we", {31'd0, drpwe}, {31'd0, s.we});
               chk("strobe_addr", {16'd0, drpaddr}, {16'd0, s.addr});
               if (s.chk_di) chk("strobe_di", {16'd0, drpdi}, {16'd0, s.di});
               if (s.gap != 0) chk("strobe_gap", cyc - last_strobe, s.gap);
            end
            last_strobe = cyc;
         end
         if (rsp_valid) begin
            if (rsp_q.size() == 0) begin
               chk("rsp_unexpected", {16'd0, rsp_data}, 32'hFFFF_FFFF);
            end else begin
               r = rsp_q.pop_front();
               chk("rsp_data", {16'd0, rsp_data}, {16'd0, r.data});
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
               chk("rsp_gap", cyc - last_strobe, r.gap);
            end
         end
      end
   end

   function automatic strobe_t mk_s(input logic we, input logic [15:0] addr,
                                    input logic [15:0] di, input bit chk_di, input int gap);
      strobe_t s;
      s.we = we;
      s.addr = addr;
      s.di = di;
      s.chk_di = chk_di;
      s.gap = gap;
      return s;
   endfunction

   function automatic rsp_t mk_r(input logic [15:0] data, input logic err, input int gap);
      rsp_t r;
      r.data = data;
      r.err = err;
      r.gap = gap;
      return r;
   endfunction

   task automatic send(input logic [1:0] op, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic [15:0] mask);
      int n;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n = n + 1;
      end
      if (!req_ready) chk("ready_wait_timeout", 32'd0, 32'd1);
      req_valid = 1'b1;
      req_op = op;
      req_addr = addr;
      req_wdata = wdata;
      req_wmask = mask;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (!(req_ready && rsp_q.size() == 0 && strobe_q.size() == 0) && n < 100) begin
         @(negedge clk);
         n = n + 1;
      end
      chk(name, rsp_q.size() + strobe_q.size() + {31'd0, !req_ready}, 32'd0);
   endtask

   initial begin : stim
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_op = 2'b00;
      req_addr = 16'h0000;
      req_wdata = 16'h0000;
      req_wmask = 16'h0000;
      repeat (2) @(negedge clk);
      chk("reset_ready", {31'd0, req_ready}, 32'd0);
      chk("reset_drpen", {31'd0, drpen}, 32'd0);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_drpdi", {16'd0, drpdi}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

      // Read 0x0014, slave answers 3 cycles after strobe with 0x3C42.
      slv_lat = 3; slv_rdata = 16'h3C42;
      strobe_q.push_back(mk_s(1'b0, 16'h0014, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h3C42, 1'b0, 4));
      send(2'b00, 16'h0014, 16'h0000, 16'h0000);
      drain("read_done");

      // Write 0x0042 to 0x0014.
      slv_lat = 2;
      strobe_q.push_back(mk_s(1'b1, 16'h0014, 16'h0042, 1'b1, 0));
      rsp_q.push_back(mk_r(16'h0042, 1'b0, 3));
      send(2'b01, 16'h0014, 16'h0042, 16'h0000);
      drain("write_done");

      // Minimum-latency write: drprdy in the first sampled cycle.
      slv_lat = 1;
      strobe_q.push_back(mk_s(1'b1, 16'h0020, 16'hBEEF, 1'b1, 0));
      rsp_q.push_back(mk_r(16'hBEEF, 1'b0, 2));
      send(2'b01, 16'h0020, 16'hBEEF, 16'h0000);
      drain("write_lat1_done");

      // RMW: (AB0C & ~00F0) | (00FF & 00F0) = ABFC.
      slv_lat = 3; slv_rdata = 16'hAB0C;
      strobe_q.push_back(mk_s(1'b0, 16'h0030, 16'h0000, 1'b0, 0));
      strobe_q.push_back(mk_s(1'b1, 16'h0030, 16'hABFC, 1'b1, 4));
      rsp_q.push_back(mk_r(16'hABFC, 1'b0, 4));
      send(2'b10, 16'h0030, 16'h00FF, 16'h00F0);
      drain("rmw_done");

      // Reserved op behaves as a read.
      slv_lat = 2; slv_rdata = 16'h5A5A;
      strobe_q.push_back(mk_s(1'b0, 16'h0040, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h5A5A, 1'b0, 3));
      send(2'b11, 16'h0040, 16'h1111, 16'hFFFF);
      drain("rsvd_done");

      // Timeouts with no drprdy: response at strobe + 9, RMW issues no write.
      slv_lat = 0;
      strobe_q.push_back(mk_s(1'b0, 16'h0050, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h0000, 1'b1, 9));
      send(2'b00, 16'h0050, 16'h0000, 16'h0000);
      drain("tmo_read_done");
      strobe_q.push_back(mk_s(1'b0, 16'h0051, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h0000, 1'b1, 9));
      send(2'b10, 16'h0051, 16'hFFFF, 16'hFFFF);
      drain("tmo_rmw_done");
      strobe_q.push_back(mk_s(1'b1, 16'h0052, 16'h7777, 1'b1, 0));
      rsp_q.push_back(mk_r(16'h0000, 1'b1, 9));
      send(2'b01, 16'h0052, 16'h7777, 16'h0000);
      drain("tmo_write_done");

      // drprdy exactly at expiry wins.
      slv_lat = 8; slv_rdata = 16'h1234;
      strobe_q.push_back(mk_s(1'b0, 16'h0060, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h1234, 1'b0, 9));
      send(2'b00, 16'h0060, 16'h0000, 16'h0000);
      drain("expiry_rdy_done");

      // One cycle too late: timeout, then the late drprdy lands in RESP and is ignored.
      slv_lat = 9; slv_rdata = 16'h4321;
      strobe_q.push_back(mk_s(1'b0, 16'h0061, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h0000, 1'b1, 9));
      send(2'b00, 16'h0061, 16'h0000, 16'h0000);
      drain("late_rdy_done");

      // Stray drprdy in IDLE: no response, still ready.
      stray_req = stray_req + 1;
      repeat (4) @(negedge clk);
      chk("stray_ready", {31'd0, req_ready}, 32'd1);

      // Reset while in WR_WAIT, then a late drprdy.
      slv_lat = 0;
      strobe_q.push_back(mk_s(1'b1, 16'h0070, 16'h9999, 1'b1, 0));
      send(2'b01, 16'h0070, 16'h9999, 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_drpen", {31'd0, drpen}, 32'd0);
      chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      rst_n = 1'b1;
      stray_req = stray_req + 1;
      repeat (3) @(negedge clk);
      chk("rst_mid_drpwe", {31'd0, drpwe}, 32'd0);
      slv_lat = 2; slv_rdata = 16'h0F0F;
      strobe_q.push_back(mk_s(1'b0, 16'h0014, 16'h0000, 1'b0, 0));
      rsp_q.push_back(mk_r(16'h0F0F, 1'b0, 3));
      send(2'b00, 16'h0014, 16'h0000, 16'h0000);
      drain("post_reset_read_done");

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
